// File: rtl/vga_timing_if.sv
// Timing-generator bundle: restart enable in, pixel strobe, syncs, position and strobes out.
interface vga_timing_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          en;
   logic          pix_ce;
   logic          hsync;
   logic          vsync;
   logic          active;
   logic [XW-1:0] xpos;
   logic [YW-1:0] ypos;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  en,
      output pix_ce, hsync, vsync, active, xpos, ypos, line_start, frame_start
   );

   modport slave (
      output en,
      input  pix_ce, hsync, vsync, active, xpos, ypos, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Video timing generator: integer pixel clock-enable divider plus registered raster counters,
// sync/active decode and line/frame strobes, all in the clk50 domain. en=0 restarts synchronously.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic          clk50,
   input  logic          rst_n,
   vga_timing_if.master  vif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

   logic [DW-1:0] r_div_cnt;
   logic          r_pix_ce;
   logic          r_started;
   logic [XW-1:0] r_xpos;
   logic [YW-1:0] r_ypos;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_active;
   logic          r_line_start;
   logic          r_frame_start;

   logic [XW-1:0] w_nx;
   logic [YW-1:0] w_ny;
   logic          w_hs_act;
   logic          w_vs_act;
   logic          w_vis;

   // Position to be loaded at the next advance edge; (0,0) until the first advance after restart.
   always_comb begin
      w_nx = '0;
      w_ny = '0;
      if (r_started) begin
         if (r_xpos == X_LAST) begin
            w_nx = '0;
            w_ny = (r_ypos == Y_LAST) ? '0 : r_ypos + 1'b1;
         end else begin
            w_nx = r_xpos + 1'b1;
            w_ny = r_ypos;
         end
      end
      w_hs_act = (32'(w_nx) >= HS_START) && (32'(w_nx) < HS_END);
      w_vs_act = (32'(w_ny) >= VS_START) && (32'(w_ny) < VS_END);
      w_vis    = (32'(w_nx) < H_ACTIVE) && (32'(w_ny) < V_ACTIVE);
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt     <= '0;
         r_pix_ce      <= 1'b0;
         r_started     <= 1'b0;
         r_xpos        <= '0;
         r_ypos        <= '0;
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (!vif.en) begin
         r_div_cnt     <= '0;
         r_pix_ce      <= 1'b0;
         r_started     <= 1'b0;
         r_xpos        <= '0;
         r_ypos        <= '0;
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div_cnt     <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
         r_pix_ce      <= (r_div_cnt == DIV_LAST);
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         if (r_pix_ce) begin
            r_started     <= 1'b1;
            r_xpos        <= w_nx;
            r_ypos        <= w_ny;
            r_line_start  <= (w_nx == '0);
            r_frame_start <= (w_nx == '0) && (w_ny == '0);
            r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            r_active      <= w_vis;
         end
      end
   end

   assign vif.pix_ce      = r_pix_ce;
   assign vif.hsync       = r_hsync;
   assign vif.vsync       = r_vsync;
   assign vif.active      = r_active;
   assign vif.xpos        = r_xpos;
   assign vif.ypos        = r_ypos;
   assign vif.line_start  = r_line_start;
   assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (divide-by-2 active-low syncs, divide-by-1 active-high syncs)
// checked every cycle against a closed-form raster model driven by random enable drops and resets.
module tb_vga_timing_gen;

   localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
   localparam int VA = 6, VFP = 2, VS = 2, VBP = 3;

   typedef struct {
      int pix_ce, hsync, vsync, active, x, y, ls, fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n0, rst_n1;
   logic run_chk = 1'b0;
   int   k0 = 0, k1 = 0;
   int   n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   vga_timing_if #(.XW(10), .YW(10)) if0 ();
   vga_timing_if #(.XW(10), .YW(10)) if1 ();

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
   ) dut0 (.clk50(clk), .rst_n(rst_n0), .vif(if0));

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1), .XW(10), .YW(10)
   ) dut1 (.clk50(clk), .rst_n(rst_n1), .vif(if1));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // k = enabled clk50 edges since the last reset/restart; the raster follows from it by arithmetic.
   function automatic exp_t model(input int k, input int d, input int hpol, input int vpol);
      exp_t e;
      int   a, p, ht, vt;
      e  = '{default: 0};
      ht = HA + HFP + HS + HBP;
      vt = VA + VFP + VS + VBP;
      e.pix_ce = (k >= 1 && (k % d) == 0) ? 1 : 0;
      a = (k >= 1) ? (k - 1) / d : 0;
      e.hsync = 1 - hpol;
      e.vsync = 1 - vpol;
      if (a >= 1) begin
         p   = a - 1;
         e.x = p % ht;
         e.y = (p / ht) % vt;
         e.ls = (((k - 1) % d) == 0 && e.x == 0) ? 1 : 0;
         e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
         e.active = (e.x < HA && e.y < VA) ? 1 : 0;
         if (e.x >= HA + HFP && e.x < HA + HFP + HS) e.hsync = hpol;
         if (e.y >= VA + VFP && e.y < VA + VFP + VS) e.vsync = vpol;
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n0)
      if (!rst_n0)     k0 <= 0;
      else if (!if0.en) k0 <= 0;
      else              k0 <= k0 + 1;

   always @(posedge clk or negedge rst_n1)
      if (!rst_n1)     k1 <= 0;
      else if (!if1.en) k1 <= 0;
      else              k1 <= k1 + 1;

   task automatic check_dut(input string nm, input exp_t e, input int pce, input int hs, input int vs,
                            input int act, input int x, input int y, input int ls, input int fs);
      chk({nm, ".pix_ce"}, pce, e.pix_ce);
      chk({nm, ".hsync"}, hs, e.hsync);
      chk({nm, ".vsync"}, vs, e.vsync);
      chk({nm, ".active"}, act, e.active);
      chk({nm, ".xpos"}, x, e.x);
      chk({nm, ".ypos"}, y, e.y);
      chk({nm, ".line_start"}, ls, e.ls);
      chk({nm, ".frame_start"}, fs, e.fs);
   endtask

   always @(negedge clk) begin
      if (run_chk) begin
         check_dut("d0", model(k0, 2, 0, 0), int'(if0.pix_ce), int'(if0.hsync), int'(if0.vsync),
                   int'(if0.active), int'(if0.xpos), int'(if0.ypos), int'(if0.line_start),
                   int'(if0.frame_start));
         check_dut("d1", model(k1, 1, 1, 1), int'(if1.pix_ce), int'(if1.hsync), int'(if1.vsync),
                   int'(if1.active), int'(if1.xpos), int'(if1.ypos), int'(if1.line_start),
                   int'(if1.frame_start));
      end
   end

   initial begin
      int found;
      rst_n0  = 1'b0;
      rst_n1  = 1'b0;
      if0.en  = 1'b1;
      if1.en  = 1'b1;
      run_chk = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n0 = 1'b1;
      rst_n1 = 1'b1;

      // Past one full frame of dut0 so the (799,12)->(0,0) wrap is exercised.
      repeat (21000) @(posedge clk);

      found = 0;
      for (int i = 0; i < 30000 && found == 0; i++) begin
         @(negedge clk);
         if (if0.xpos == 10'd300 && if0.ypos == 10'd10) found = 1;
      end
      chk("wait_pos_300_10", found, 1);
      @(posedge clk);
      #1 if0.en = 1'b0;
      repeat (1 + $urandom_range(0, 10)) @(posedge clk);
      #1 if0.en = 1'b1;

      for (int it = 0; it < 15; it++) begin
         repeat ($urandom_range(50, 2000)) @(posedge clk);
         case ($urandom_range(0, 2))
            0: begin
               #1 if0.en = 1'b0;
               repeat (1 + $urandom_range(0, 20)) @(posedge clk);
               #1 if0.en = 1'b1;
            end
            1: begin
               #1 if1.en = 1'b0;
               repeat (1 + $urandom_range(0, 20)) @(posedge clk);
               #1 if1.en = 1'b1;
            end
            default: begin
               #2 rst_n1 = 1'b0;
               #1;
               chk("async.hsync", int'(if1.hsync), 0);
               chk("async.vsync", int'(if1.vsync), 0);
               chk("async.xpos", int'(if1.xpos), 0);
               chk("async.pix_ce", int'(if1.pix_ce), 0);
               chk("async.active", int'(if1.active), 0);
               repeat (1 + $urandom_range(0, 5)) @(posedge clk);
               #1 rst_n1 = 1'b1;
            end
         endcase
      end

      repeat (100) @(posedge clk);
      @(negedge clk);
      #1 run_chk = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
